// File: rtl/dmem_bus_responder.sv
// Word-organised data-memory responder: valid/ready request, WAIT_CYCLES wait states, then a held response.
// Define DMEM_RESP_STATS_EN to add saturating load/store/error counters.
module dmem_bus_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
`ifdef DMEM_RESP_STATS_EN
  ,
  output logic [15:0] stat_loads_o,
  output logic [15:0] stat_stores_o,
  output logic [15:0] stat_errs_o
`endif
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q;
  logic            req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]     rsp_rdata_q;
  logic [3:0]      cnt_q;
  logic            wr_q;
  logic [2:0]      f3_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  function automatic logic legal_f(logic wr, logic [2:0] f3, logic [31:0] addr);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~addr[0];
      3'b010:  ok = (addr[1:0] == 2'b00);
      3'b100:  ok = ~wr;
      3'b101:  ok = ~wr & ~addr[0];
      default: ok = 1'b0;
    endcase
    return ok && ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
  endfunction

  // In IDLE the access (zero-wait case) uses the live request; in WAIT it uses the captured one.
  logic          in_idle, req_legal, acc_fire, acc_wr;
  logic [2:0]    acc_f3;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata, mem_word, wlane_d, rdata_d;
  logic [3:0]    be_d;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign in_idle   = (state_q == S_IDLE);
  assign req_legal = legal_f(req_write_i, req_funct3_i, req_addr_i);
  assign acc_wr    = in_idle ? req_write_i : wr_q;
  assign acc_f3    = in_idle ? req_funct3_i : f3_q;
  assign acc_addr  = in_idle ? req_addr_i[AW+1:0] : addr_q;
  assign acc_wdata = in_idle ? req_wdata_i : wdata_q;
  assign acc_fire  = rst_ni &&
                     ((in_idle && req_valid_i && req_legal && (WAIT_CYCLES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd0)));
  assign mem_word  = mem_q[acc_addr[AW+1:2]];
  assign byte_sel  = mem_word[{acc_addr[1:0], 3'b000} +: 8];
  assign half_sel  = acc_addr[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    be_d    = 4'b1111;
    wlane_d = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << acc_addr[1:0];
        wlane_d = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlane_d = {2{acc_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_d = mem_word;
    case (acc_f3)
      3'b000:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  rdata_d = {{16{half_sel[15]}}, half_sel};
      3'b100:  rdata_d = {24'd0, byte_sel};
      3'b101:  rdata_d = {16'd0, half_sel};
      default: ;
    endcase
    if (acc_wr) rdata_d = 32'd0;
  end

  always_ff @(posedge clk_i) begin
    if (acc_fire && acc_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[acc_addr[AW+1:2]][8*b +: 8] <= wlane_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            wr_q        <= req_write_i;
            f3_q        <= req_funct3_i;
            addr_q      <= req_addr_i[AW+1:0];
            wdata_q     <= req_wdata_i;
            req_ready_q <= 1'b0;
            if (!req_legal) begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else if (WAIT_CYCLES == 0) begin
              rsp_rdata_q <= rdata_d;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              cnt_q   <= CNT_INIT;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_rdata_q <= rdata_d;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

`ifdef DMEM_RESP_STATS_EN
  logic [15:0] loads_q, stores_q, errs_q;
  logic        rsp_hs;

  function automatic logic [15:0] sat_inc(logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  assign rsp_hs = rsp_valid_q && rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loads_q  <= 16'd0;
      stores_q <= 16'd0;
      errs_q   <= 16'd0;
    end else if (rsp_hs) begin
      if (rsp_err_q)  errs_q   <= sat_inc(errs_q);
      else if (wr_q)  stores_q <= sat_inc(stores_q);
      else            loads_q  <= sat_inc(loads_q);
    end
  end

  assign stat_loads_o  = loads_q;
  assign stat_stores_o = stores_q;
  assign stat_errs_o   = errs_q;
`endif

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Scoreboard bench for dmem_bus_responder: directed requests push expected responses, a negedge monitor checks them.
module tb_dmem_bus_responder;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
`ifdef DMEM_RESP_STATS_EN
  logic [15:0] st_loads, st_stores, st_errs;
`endif

  always #5 clk = ~clk;

  dmem_bus_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err)
`ifdef DMEM_RESP_STATS_EN
    , .stat_loads_o(st_loads), .stat_stores_o(st_stores), .stat_errs_o(st_errs)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   passes = 0;
  int   ncyc = 0;
  logic prev_vld = 1'b0;
  exp_t mon_e;
  int   mon_lat;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, expv);
  endfunction

  // Monitor: records accepts, checks latency on response rise and data/err/req_ready while a response is shown.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      prev_vld = 1'b0;
    end else begin
      ncyc++;
      if (req_valid && req_ready) acc_q.push_back(ncyc);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          mon_e = exp_q[0];
          if (!prev_vld) begin
            if (acc_q.size() == 0) chk("latency_no_accept", 32'(acc_q.size()), 32'd1);
            else begin
              mon_lat = ncyc - acc_q.pop_front();
              chk("latency", 32'(mon_lat), 32'(mon_e.lat));
            end
          end
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      prev_vld = rsp_valid && !rsp_ready;
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic er);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    e.lat   = er ? 1 : W + 1;
    exp_q.push_back(e);
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    int n = 0;
    push_exp(exp_rd, exp_err);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req(1'b1, 3'b000, 32'h11, 32'h80, 32'h0, 1'b0);
    do_req(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, 3'b100, 32'h11, 32'h0, 32'h00000080, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
    do_req(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    do_req(1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
    do_req(1'b1, 3'b001, 32'h13, 32'h5555, 32'h0, 1'b1);
    do_req(1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0);
    do_req(1'b1, 3'b010, 32'h400, 32'h11111111, 32'h0, 1'b1);
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0);
    do_req(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
    do_req(1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1);
    do_req(1'b1, 3'b000, 32'h13, 32'hFFFFFFA5, 32'h0, 1'b0);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hA5AD80EF, 1'b0);
    do_req(1'b1, 3'b001, 32'h16, 32'h1234ABCD, 32'h0, 1'b0);
    do_req(1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFFABCD, 1'b0);
    do_req(1'b0, 3'b101, 32'h16, 32'h0, 32'h0000ABCD, 1'b0);
    do_req(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);

    // Backpressure: hold rsp_ready low while a competing request is presented.
    push_exp(32'hA5AD80EF, 1'b0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_rsp_valid_seen", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h3FC; req_wdata = 32'h0;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_no_accept", 32'(req_ready), 32'd0);
    chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();

    // Reset in WAIT drops the pending store.
    do_req(1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstwait_req_ready", 32'(req_ready), 32'd1);
    chk("rstwait_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstwait_rsp_rdata", rsp_rdata, 32'd0);
    chk("rstwait_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
